// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and lane helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_t;

    // Access width; unsigned variants share the width of their signed form,
    // and every unlisted encoding is treated as a full word.
    function automatic lsu_size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = SZ_B;
            F3_H, F3_HU: f3_size = SZ_H;
            default:     f3_size = SZ_W;
        endcase
    endfunction

    function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3_size(f3))
            SZ_B:    calc_be = 4'b0001 << off;
            SZ_H:    calc_be = off[1] ? 4'b1100 : 4'b0011;
            default: calc_be = 4'b1111;
        endcase
    endfunction

    // Store data is replicated across lanes so the byte enables alone pick the target.
    function automatic logic [31:0] calc_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3_size(f3))
            SZ_B:    calc_wdata = {4{d[7:0]}};
            SZ_H:    calc_wdata = {2{d[15:0]}};
            default: calc_wdata = d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane select and sign/zero extension of a bus read word.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte/halfword and extend it according to funct3.
    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: drives a req/ack data bus for one access at a time and stalls
// the core until it completes. Optional macro LSU_MISALIGN_TRAP_EN turns
// misaligned H/W accesses into an immediate misalign completion.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BE_W  = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lsu_valid,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] ALUout,
    input  logic [WIDTH-1:0] RegOp2,
    output logic [WIDTH-1:0] ReadData,
    output logic             lsu_done,
    output logic             stall,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic             misalign,
`endif
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [BE_W-1:0]  mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    lsu_state_t       r_state;
    lsu_state_t       w_next;
    logic             w_start;
    logic             w_trap;
    logic             r_we;
    logic [WIDTH-1:0] r_addr;
    logic [BE_W-1:0]  r_be;
    logic [WIDTH-1:0] r_wdata;
    logic [2:0]       r_f3;
    logic [1:0]       r_off;
    logic [WIDTH-1:0] r_rdata;
    logic [WIDTH-1:0] w_load;

    assign w_start = lsu_valid & (MemRead | MemWrite);

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_misalign;
    assign w_trap = ((f3_size(funct3) == SZ_H) & ALUout[0]) |
                    ((f3_size(funct3) == SZ_W) & (ALUout[1:0] != 2'b00));
    assign misalign = r_misalign;

    // Flag a trapped access during its DONE cycle only.
    always_ff @(posedge clk) begin
        if (rst) r_misalign <= 1'b0;
        else     r_misalign <= (r_state == IDLE) & w_start & w_trap;
    end
`else
    assign w_trap = 1'b0;
`endif

    lsu_load_align u_align (
        .i_rdata  (mem_rdata),
        .i_off    (r_off),
        .i_funct3 (r_f3),
        .o_data   (w_load)
    );

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;
    assign ReadData  = r_rdata;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state and handshake outputs; start is ignored in DONE because the
    // upstream inputs still belong to the instruction just completed.
    always_comb begin
        w_next   = r_state;
        stall    = 1'b0;
        mem_req  = 1'b0;
        lsu_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    stall  = 1'b1;
                    w_next = w_trap ? DONE : REQ;
                end
            end
            REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) w_next = DONE;
            end
            DONE: begin
                lsu_done = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Capture the bus request at launch and the extended load word on ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_f3    <= '0;
            r_off   <= '0;
            r_rdata <= '0;
        end else begin
            if ((r_state == IDLE) && w_start && !w_trap) begin
                r_we    <= MemWrite & ~MemRead;
                r_addr  <= {ALUout[WIDTH-1:2], 2'b00};
                r_be    <= calc_be(funct3, ALUout[1:0]);
                r_wdata <= calc_wdata(funct3, RegOp2);
                r_f3    <= funct3;
                r_off   <= ALUout[1:0];
            end
            if ((r_state == REQ) && mem_ack && !r_we) begin
                r_rdata <= w_load;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a cycle-level reference model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid, MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUout, RegOp2;
    logic [31:0] ReadData;
    logic        lsu_done, stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    always #5 clk = ~clk;

    load_store_unit #(.WIDTH(32), .BE_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .lsu_valid (lsu_valid),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .funct3    (funct3),
        .ALUout    (ALUout),
        .RegOp2    (RegOp2),
        .ReadData  (ReadData),
        .lsu_done  (lsu_done),
        .stall     (stall),
`ifdef LSU_MISALIGN_TRAP_EN
        .misalign  (misalign),
`endif
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Expected per-cycle behaviour, set by the driver for the cycle in progress.
    bit          exp_stall, exp_req, exp_done, exp_mis, exp_we;
    logic [31:0] exp_addr, exp_wdata, m_rd;
    logic [3:0]  exp_be;

    // Event counters and captured bus values maintained by the compare process.
    int          cnt_stall = 0, cnt_req = 0, cnt_done = 0, cnt_mis = 0;
    int          b_stall, b_req, b_done, b_mis;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int lane_of(input logic [2:0] f3, input logic [1:0] off);
        int n = nbytes(f3);
        if (n == 4) return 0;
        if (n == 2) return int'(off) & 2;
        return int'(off);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
        int n = nbytes(f3);
        int v = ((1 << n) - 1) << lane_of(f3, off);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        int n = nbytes(f3);
        if (n == 1) return {24'd0, d[7:0]} * 32'h01010101;
        if (n == 2) return {16'd0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdat);
        int n = nbytes(f3);
        logic [31:0] v    = rdat >> (8 * lane_of(f3, off));
        logic [31:0] mask = 32'hFFFF_FFFF >> (32 - 8 * n);
        v = v & mask;
        if (n < 4 && !f3[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit m_mis(input logic [2:0] f3, input logic [1:0] off);
`ifdef LSU_MISALIGN_TRAP_EN
        int n = nbytes(f3);
        return (n == 2 && off[0]) || (n == 4 && off != 2'b00);
`else
        return 1'b0 & f3[0] & off[0];
`endif
    endfunction

    // Compare DUT outputs with the model once per cycle, away from the clock edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", {31'd0, stall}, {31'd0, exp_stall});
            check("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
            check("lsu_done", {31'd0, lsu_done}, {31'd0, exp_done});
            check("ReadData", ReadData, m_rd);
`ifdef LSU_MISALIGN_TRAP_EN
            check("misalign", {31'd0, misalign}, {31'd0, exp_mis});
            if (misalign) cnt_mis++;
`endif
            if (mem_req && exp_req) begin
                check("mem_addr", mem_addr, exp_addr);
                check("mem_be", {28'd0, mem_be}, {28'd0, exp_be});
                check("mem_wdata", mem_wdata, exp_wdata);
                check("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
            end
            if (stall)    cnt_stall++;
            if (lsu_done) cnt_done++;
            if (mem_req) begin
                cnt_req++;
                cap_addr  = mem_addr;
                cap_be    = mem_be;
                cap_wdata = mem_wdata;
                cap_we    = mem_we;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic mark();
        b_stall = cnt_stall;
        b_req   = cnt_req;
        b_done  = cnt_done;
        b_mis   = cnt_mis;
    endtask

    task automatic idle_cycle(input bit ack);
        @(posedge clk); #1;
        lsu_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; mem_ack = ack;
        exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0; exp_mis = 1'b0;
    endtask

    task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdat, input int waits);
        bit mis = m_mis(f3, addr[1:0]);
        @(posedge clk); #1;
        mark();
        lsu_valid = 1'b1; MemRead = rd; MemWrite = wr; funct3 = f3;
        ALUout = addr; RegOp2 = wd; mem_ack = 1'b0; mem_rdata = rdat;
        exp_stall = 1'b1; exp_req = 1'b0; exp_done = 1'b0; exp_mis = 1'b0;
        exp_addr  = {addr[31:2], 2'b00};
        exp_be    = m_be(f3, addr[1:0]);
        exp_wdata = m_wdata(f3, wd);
        exp_we    = wr && !rd;
        if (!mis) begin
            for (int i = 0; i <= waits; i++) begin
                @(posedge clk); #1;
                exp_req = 1'b1; exp_stall = 1'b1; mem_ack = (i == waits);
            end
        end
        @(posedge clk); #1;
        mem_ack = 1'b0; exp_req = 1'b0; exp_stall = 1'b0; exp_done = 1'b1; exp_mis = mis;
        if (rd && !mis) m_rd = m_load(f3, addr[1:0], rdat);
        idle_cycle(1'b0);
    endtask

    initial begin
        rst = 1'b1; lsu_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        funct3 = 3'b000; ALUout = '0; RegOp2 = '0; mem_ack = 1'b0; mem_rdata = '0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0; exp_mis = 1'b0; exp_we = 1'b0;
        exp_addr = '0; exp_wdata = '0; exp_be = '0; m_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_ReadData", ReadData, 32'h0);
        check("rst_mem_req", {31'd0, mem_req}, 32'h0);
        check("rst_mem_we", {31'd0, mem_we}, 32'h0);
        check("rst_mem_be", {28'd0, mem_be}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_lsu_done", {31'd0, lsu_done}, 32'h0);

        // LB at 0x1003, ack on first REQ cycle
        access(1'b1, 1'b0, F3_B, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0);
        check("LB_ReadData", ReadData, 32'hFFFF_FF80);
        check("LB_be", {28'd0, cap_be}, 32'h8);
        check("LB_stall_cycles", cnt_stall - b_stall, 2);
        check("LB_done_pulses", cnt_done - b_done, 1);

        access(1'b1, 1'b0, F3_BU, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0);
        check("LBU_ReadData", ReadData, 32'h0000_0080);

        access(1'b0, 1'b1, F3_H, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 0);
        check("SH_we", {31'd0, cap_we}, 32'h1);
        check("SH_be", {28'd0, cap_be}, 32'hC);
        check("SH_wdata", cap_wdata, 32'hABCD_ABCD);
        check("SH_addr", cap_addr, 32'h0000_2000);
        check("SH_ReadData_kept", ReadData, 32'h0000_0080);

        access(1'b1, 1'b0, F3_W, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 3);
        check("LW_ReadData", ReadData, 32'hDEAD_BEEF);
        check("LW_req_cycles", cnt_req - b_req, 4);
        check("LW_stall_cycles", cnt_stall - b_stall, 5);
        check("LW_done_pulses", cnt_done - b_done, 1);

`ifdef LSU_MISALIGN_TRAP_EN
        access(1'b1, 1'b0, F3_W, 32'h0000_1002, 32'h0, 32'h1234_5678, 0);
        check("TRAP_no_req", cnt_req - b_req, 0);
        check("TRAP_done", cnt_done - b_done, 1);
        check("TRAP_misalign", cnt_mis - b_mis, 1);
        check("TRAP_ReadData_kept", ReadData, 32'hDEAD_BEEF);
`endif

        // Further lane/extension patterns checked by the model every cycle
        access(1'b1, 1'b0, F3_H,  32'h0000_0002, 32'h0, 32'h80AA_BBCC, 1);
        check("LH_hi_ReadData", ReadData, 32'hFFFF_80AA);
        access(1'b1, 1'b0, F3_HU, 32'h0000_0000, 32'h0, 32'h80AA_BBCC, 0);
        check("LHU_lo_ReadData", ReadData, 32'h0000_BBCC);
        access(1'b0, 1'b1, F3_B,  32'h0000_0005, 32'h1234_567E, 32'h0, 2);
        check("SB_be", {28'd0, cap_be}, 32'h2);
        check("SB_wdata", cap_wdata, 32'h7E7E_7E7E);
        access(1'b1, 1'b0, F3_B,  32'h0000_0001, 32'h0, 32'h1234_567F, 0);
        check("LB_pos_ReadData", ReadData, 32'h0000_0056);
        access(1'b1, 1'b0, 3'b011, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 1);
        check("F3_011_ReadData", ReadData, 32'hCAFE_F00D);
        access(1'b1, 1'b1, F3_W,  32'h0000_000C, 32'h5555_5555, 32'h0BAD_CAFE, 0);
        check("RW_is_load_we", {31'd0, cap_we}, 32'h0);
        access(1'b1, 1'b0, F3_H,  32'h0000_1003, 32'h0, 32'hFFEE_8001, 0);
`ifndef LSU_MISALIGN_TRAP_EN
        check("LH_odd_ReadData", ReadData, 32'hFFFF_FFEE);
`endif

        // Bubbles and a stray ack while idle must not start or complete anything
        @(posedge clk); #1;
        lsu_valid = 1'b0; MemRead = 1'b1;
        @(posedge clk); #1;
        lsu_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        mem_rdata = 32'h1111_1111;
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        // Reset during the second REQ cycle, ack one cycle later
        @(posedge clk); #1;
        mark();
        lsu_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = F3_W;
        ALUout = 32'h0000_0040; mem_rdata = 32'h5555_AAAA; mem_ack = 1'b0;
        exp_stall = 1'b1; exp_req = 1'b0; exp_done = 1'b0;
        exp_addr = 32'h0000_0040; exp_be = 4'hF; exp_we = 1'b0;
        exp_wdata = m_wdata(F3_W, RegOp2);
        @(posedge clk); #1;
        exp_req = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; lsu_valid = 1'b0; MemRead = 1'b0; mem_ack = 1'b1;
        m_rd = 32'h0; exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0;
        check("RST_be_cleared", {28'd0, mem_be}, 32'h0);
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        check("RST_no_done", cnt_done - b_done, 0);
        check("RST_ReadData", ReadData, 32'h0);

        idle_cycle(1'b0);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
